// File: rtl/imm_ext_queue.sv
// Immediate extender feeding a DEPTH-entry FIFO, so decode can run ahead of a stalled execute.
// Extension happens on the input side; the queue stores finished DATA_W-bit values.
module imm_ext_queue #(
   parameter int unsigned IMM_W  = 16,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 2
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [IMM_W-1:0]       imm,
   input  logic [1:0]             mode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      ext_imm,
   output logic [$clog2(DEPTH):0] count
);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned PadW = DATA_W - IMM_W;

   logic [DATA_W-1:0] sext;
   logic [DATA_W-1:0] ext_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q;
   logic [PtrW-1:0]   rd_ptr_q;
   logic [CntW-1:0]   count_q;
   logic [CntW-1:0]   count_d;
   logic              push;
   logic              pop;

   assign sext = {{PadW{imm[IMM_W-1]}}, imm};

   always_comb begin
      ext_d = '0;
      case (mode)
         2'b00:   ext_d = {{PadW{1'b0}}, imm};
         2'b01:   ext_d = sext;
         2'b10:   ext_d = {imm, {PadW{1'b0}}};
         // Branch offset: the two bits shifted out of the top are simply dropped.
         default: ext_d = {sext[DATA_W-3:0], 2'b00};
      endcase
   end

   // Ready looks only at registered occupancy, keeping out_ready off the input path.
   assign in_ready  = count_q < CntW'(DEPTH);
   assign out_valid = count_q != '0;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign ext_imm   = mem_q[rd_ptr_q];
   assign count     = count_q;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge CLK) begin
      if (RST || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= ext_d;
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_imm_ext_queue.sv
// Directed bench for imm_ext_queue: stimulus queues expected values, a negedge monitor pops
// and compares them whenever the DUT completes an output handshake.
module tb_imm_ext_queue;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] imm = '0;
   logic [1:0]  mode = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] ext_imm;
   logic [1:0]  count;

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   logic [31:0] expq[$];

   imm_ext_queue #(
      .IMM_W  (16),
      .DATA_W (32),
      .DEPTH  (2)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .imm       (imm),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ext_imm   (ext_imm),
      .count     (count)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] i, input logic [1:0] m);
      in_valid = v;
      imm      = i;
      mode     = m;
   endtask

   // Monitor: a completed pop must match the oldest outstanding expectation.
   always @(negedge CLK) begin
      if (!RST && !flush && out_valid && out_ready) begin
         if (expq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got %h required none", ext_imm);
         end else begin
            chk("ext_imm", ext_imm, expq.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] vin  [5];
      logic [1:0]  vmode[5];
      logic [31:0] vexp [5];
      vin[0] = 16'h8001; vmode[0] = 2'b00; vexp[0] = 32'h0000_8001;
      vin[1] = 16'h8001; vmode[1] = 2'b01; vexp[1] = 32'hFFFF_8001;
      vin[2] = 16'h1234; vmode[2] = 2'b10; vexp[2] = 32'h1234_0000;
      vin[3] = 16'hFFFF; vmode[3] = 2'b11; vexp[3] = 32'hFFFF_FFFC;
      vin[4] = 16'h7FFF; vmode[4] = 2'b11; vexp[4] = 32'h0001_FFFC;

      step();
      step();
      RST = 1'b0;
      chk("reset_count", 32'(count), 32'd0);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);

      // Single pushes through every extension mode, consumer always ready.
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, vin[k], vmode[k]);
         expq.push_back(vexp[k]);
         chk("no_bypass_out_valid", 32'(out_valid), 32'd0);
         step();
         drive(1'b0, '0, '0);
         chk("single_count", 32'(count), 32'd1);
         chk("single_out_valid", 32'(out_valid), 32'd1);
         step();
         chk("single_drain_count", 32'(count), 32'd0);
      end

      // Fill, then hold a third request against a full queue.
      out_ready = 1'b0;
      drive(1'b1, 16'h0001, 2'b00); expq.push_back(32'h1); step();
      drive(1'b1, 16'h0002, 2'b00); expq.push_back(32'h2); step();
      chk("full_count", 32'(count), 32'd2);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      drive(1'b1, 16'h0003, 2'b00); expq.push_back(32'h3);
      step();
      chk("full_refuse_count", 32'(count), 32'd2);
      step();
      chk("full_hold_count", 32'(count), 32'd2);
      // Pop while full: push still refused.
      out_ready = 1'b1;
      step();
      chk("full_pop_count", 32'(count), 32'd1);
      chk("after_pop_in_ready", 32'(in_ready), 32'd1);
      step();
      chk("push_pop_count", 32'(count), 32'd1);
      drive(1'b0, '0, '0);
      step();
      chk("fill_drain_count", 32'(count), 32'd0);

      // Back-to-back streaming, pointers wrap several times.
      for (int k = 1; k <= 5; k++) begin
         drive(1'b1, 16'(k), 2'b00);
         expq.push_back(32'(k));
         step();
         chk("wrap_count", 32'(count), 32'd1);
      end
      drive(1'b0, '0, '0);
      step();
      chk("wrap_drain_count", 32'(count), 32'd0);

      // Flush while full with both handshakes requested.
      out_ready = 1'b0;
      drive(1'b1, 16'h000A, 2'b00); expq.push_back(32'hA); step();
      drive(1'b1, 16'h000B, 2'b00); expq.push_back(32'hB); step();
      chk("pre_flush_count", 32'(count), 32'd2);
      drive(1'b1, 16'h000C, 2'b00);
      flush = 1'b1;
      out_ready = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, '0, '0);
      expq.delete();
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);

      // Flush beats a push that would otherwise be accepted.
      out_ready = 1'b0;
      drive(1'b1, 16'h000D, 2'b00); expq.push_back(32'hD); step();
      drive(1'b1, 16'h000E, 2'b00);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, '0, '0);
      expq.delete();
      chk("flush_push_count", 32'(count), 32'd0);
      out_ready = 1'b1;
      step();
      step();
      chk("post_flush_out_valid", 32'(out_valid), 32'd0);

      // Reset mid-operation: nothing changes until the clock edge.
      out_ready = 1'b0;
      drive(1'b1, 16'h0055, 2'b00); expq.push_back(32'h55); step();
      chk("pre_reset_count", 32'(count), 32'd1);
      drive(1'b1, 16'h0066, 2'b00);
      RST = 1'b1;
      #2;
      chk("sync_reset_count", 32'(count), 32'd1);
      chk("sync_reset_out_valid", 32'(out_valid), 32'd1);
      step();
      RST = 1'b0;
      drive(1'b0, '0, '0);
      expq.delete();
      chk("reset_mid_count", 32'(count), 32'd0);
      chk("reset_mid_out_valid", 32'(out_valid), 32'd0);
      chk("reset_mid_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      step();
      step();

      chk("scoreboard_empty", 32'(expq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
